// File: rtl/dma_rd_channel_pkg.sv
// rtl/dma_rd_channel_pkg.sv - shared constants and state encoding for the DMA read channel
package dma_rd_channel_pkg;

  localparam logic [2:0] MIG_WR = 3'b000;
  localparam logic [2:0] MIG_RD = 3'b001;

  localparam int DEFAULT_BURST_LEN = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } chan_state_t;

endpackage

// File: rtl/dma_rd_channel_if.sv
// rtl/dma_rd_channel_if.sv - engine stream and MIG read-port signals of one DMA read channel
interface dma_rd_channel_if #(
  parameter int ADDR_W = 30,
  parameter int DQ_W   = 32
);

  logic              reads_en;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       ob_data;
  logic              ob_we;
  logic              busy;
  logic              done;
  logic              cmd_en;
  logic [2:0]        cmd_instr;
  logic [5:0]        cmd_bl;
  logic [ADDR_W-1:0] cmd_byte_addr;
  logic              cmd_full;
  logic              rd_en;
  logic [DQ_W-1:0]   rd_data;
  logic              rd_empty;

  modport master (
    input  reads_en, addr, cmd_full, rd_data, rd_empty,
    output ob_data, ob_we, busy, done, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, rd_en
  );

  modport slave (
    output reads_en, addr, cmd_full, rd_data, rd_empty,
    input  ob_data, ob_we, busy, done, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, rd_en
  );

endinterface

// File: rtl/dma_rd_channel_word_splitter.sv
// rtl/dma_rd_channel_word_splitter.sv - splits a 32-bit FIFO word into two 16-bit beats, low half first
module dma_rd_channel_word_splitter #(
  parameter int DQ_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [DQ_W-1:0] din,
  output logic [15:0]     dout,
  output logic            dvalid,
  output logic            pending
);

  logic [15:0] hi_q;

  // flush wins over load so an aborted pop never reaches the engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout    <= '0;
      hi_q    <= '0;
      dvalid  <= 1'b0;
      pending <= 1'b0;
    end else if (flush) begin
      dvalid  <= 1'b0;
      pending <= 1'b0;
    end else if (load) begin
      dout    <= din[15:0];
      hi_q    <= din[DQ_W-1:16];
      dvalid  <= 1'b1;
      pending <= 1'b1;
    end else if (pending) begin
      dout    <= hi_q;
      dvalid  <= 1'b1;
      pending <= 1'b0;
    end else begin
      dvalid  <= 1'b0;
    end
  end

endmodule

// File: rtl/dma_rd_channel.sv
// rtl/dma_rd_channel.sv - issues one MIG burst read per request and streams it to an engine as 16-bit words
module dma_rd_channel
  import dma_rd_channel_pkg::*;
#(
  parameter int BURST_LEN = DEFAULT_BURST_LEN,
  parameter int ADDR_W    = 30,
  parameter int DQ_W      = 32
) (
  input logic              clk,
  input logic              rst_n,
  dma_rd_channel_if.master bus
);

  localparam logic [7:0] HALF      = 8'(BURST_LEN / 2);
  localparam logic [7:0] HALF_M1   = 8'(BURST_LEN / 2 - 1);
  localparam logic [7:0] LAST_WORD = 8'(BURST_LEN - 1);
  localparam logic [5:0] BL_FIELD  = 6'(BURST_LEN / 2 - 1);

  chan_state_t       state, state_nxt;
  logic              armed;
  logic [7:0]        pops;
  logic [7:0]        words;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;

  logic              start;
  logic              flush;
  logic              emit;
  logic              last_emit;
  logic              drain_end;
  logic              cmd_abort;
  logic              pending;
  logic              split_we;
  logic [15:0]       split_data;

  logic              cmd_en_c;
  logic [2:0]        cmd_instr_c;
  logic [5:0]        cmd_bl_c;
  logic              rd_en_c;

  // armed keeps a held-high reads_en from retriggering after a burst
  assign start     = (state == IDLE) && bus.reads_en && armed;
  assign cmd_abort = (state == CMD) && !bus.reads_en;
  assign flush     = !((state == READ) && bus.reads_en);
  assign emit      = !flush && (rd_en_c || pending);
  assign last_emit = emit && (words == LAST_WORD);
  assign drain_end = (state == DRAIN) && ((pops == HALF) || (rd_en_c && (pops == HALF_M1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = CMD;
      CMD: begin
        if (!bus.reads_en)     state_nxt = IDLE;
        else if (!bus.cmd_full) state_nxt = READ;
      end
      READ: begin
        if (done_q)            state_nxt = IDLE;
        else if (!bus.reads_en) state_nxt = DRAIN;
      end
      DRAIN: if (drain_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_en_c    = 1'b0;
    cmd_instr_c = '0;
    cmd_bl_c    = '0;
    rd_en_c     = 1'b0;
    case (state)
      CMD: begin
        if (bus.reads_en && !bus.cmd_full) begin
          cmd_en_c    = 1'b1;
          cmd_instr_c = MIG_RD;
          cmd_bl_c    = BL_FIELD;
        end
      end
      READ:  rd_en_c = !bus.rd_empty && bus.reads_en && !pending && (pops != HALF);
      // drain only what was commanded, so the MIG FIFO is left empty for the next burst
      DRAIN: rd_en_c = !bus.rd_empty && (pops != HALF);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed  <= 1'b1;
      pops   <= '0;
      words  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
    end else begin
      if (!bus.reads_en) armed <= 1'b1;
      else if (start)    armed <= 1'b0;

      if (start) begin
        pops   <= '0;
        words  <= '0;
        addr_q <= {bus.addr[ADDR_W-1:2], 2'b00};
      end else begin
        if (rd_en_c) pops  <= pops + 8'd1;
        if (emit)    words <= words + 8'd1;
      end

      done_q <= last_emit;

      if (start)                                     busy_q <= 1'b1;
      else if (last_emit || cmd_abort || drain_end)  busy_q <= 1'b0;
    end
  end

  dma_rd_channel_word_splitter #(.DQ_W(DQ_W)) u_splitter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (rd_en_c),
    .flush   (flush),
    .din     (bus.rd_data),
    .dout    (split_data),
    .dvalid  (split_we),
    .pending (pending)
  );

  assign bus.ob_data       = split_data;
  assign bus.ob_we         = split_we;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.cmd_en        = cmd_en_c;
  assign bus.cmd_instr     = cmd_instr_c;
  assign bus.cmd_bl        = cmd_bl_c;
  assign bus.cmd_byte_addr = addr_q;
  assign bus.rd_en         = rd_en_c;

endmodule

// File: tb/tb_dma_rd_channel.sv
// tb/tb_dma_rd_channel.sv - directed self-checking bench for dma_rd_channel with a MIG read FIFO model
module tb_dma_rd_channel;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_rd_channel_if #(.ADDR_W(30), .DQ_W(32)) bus ();

  dma_rd_channel #(.BURST_LEN(16), .ADDR_W(30), .DQ_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // MIG read FIFO model, first-word-fall-through
  logic [31:0] mem [0:63];
  logic [5:0]  wr_ptr = '0;
  logic [5:0]  rd_ptr = '0;
  logic        stall  = 1'b0;

  assign bus.rd_data  = mem[rd_ptr];
  assign bus.rd_empty = (wr_ptr == rd_ptr) || stall;

  always @(posedge clk) if (bus.rd_en && !bus.rd_empty) rd_ptr <= rd_ptr + 6'd1;

  // observation counters, sampled on the falling edge
  int          cyc = 0, ncap = 0, ncmd = 0, ndone = 0, npops = 0, nbad = 0, done_pos = 0, cmd_cyc = 0;
  logic [15:0] cap  [0:511];
  int          capc [0:511];
  logic [29:0] cmd_addr_s;
  logic [5:0]  cmd_bl_s;
  logic [2:0]  cmd_instr_s;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (bus.ob_we) begin
        cap[ncap]  <= bus.ob_data;
        capc[ncap] <= cyc;
        ncap       <= ncap + 1;
      end
      if (bus.cmd_en) begin
        ncmd        <= ncmd + 1;
        cmd_addr_s  <= bus.cmd_byte_addr;
        cmd_bl_s    <= bus.cmd_bl;
        cmd_instr_s <= bus.cmd_instr;
        cmd_cyc     <= cyc;
        if (bus.cmd_full) nbad <= nbad + 1;
      end
      if (bus.done) begin
        ndone    <= ndone + 1;
        done_pos <= ncap + 1;
        if (!bus.ob_we || bus.busy) nbad <= nbad + 1;
      end
      if (bus.rd_en && !bus.rd_empty) npops <= npops + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill(input logic [15:0] base);
    wr_ptr = rd_ptr;
    for (int k = 0; k < 8; k++) begin
      mem[wr_ptr] = {base + 16'(2 * k + 1), base + 16'(2 * k)};
      wr_ptr      = wr_ptr + 6'd1;
    end
  endtask

  // sel 0 waits on pops, sel 1 on captured words, both relative to base
  task automatic wait_count(input string name, input int sel, input int base, input int target);
    int n = 0;
    int cur;
    cur = (sel == 0) ? npops - base : ncap - base;
    while (cur < target && n < 60) begin
      step(1);
      n++;
      cur = (sel == 0) ? npops - base : ncap - base;
    end
    check(name, 32'(cur >= target), 32'd1);
  endtask

  task automatic check_words(input string tag, input int b, input int count, input logic [15:0] base);
    for (int i = 0; i < count; i++) check({tag, " word"}, 32'(cap[b + i]), 32'(base + 16'(i)));
  endtask

  task automatic run_burst(input string tag, input logic [29:0] a, input logic [15:0] base,
                           input logic [29:0] exp_addr);
    int b_cap, b_cmd, b_done, b_pops, b_bad;
    fill(base);
    b_cap = ncap; b_cmd = ncmd; b_done = ndone; b_pops = npops; b_bad = nbad;
    bus.addr     = a;
    bus.reads_en = 1'b1;
    step(25);
    bus.reads_en = 1'b0;
    step(2);
    check({tag, " cmd count"}, 32'(ncmd - b_cmd), 32'd1);
    check({tag, " cmd addr"}, 32'(cmd_addr_s), 32'(exp_addr));
    check({tag, " cmd bl"}, 32'(cmd_bl_s), 32'd7);
    check({tag, " cmd instr"}, 32'(cmd_instr_s), 32'd1);
    check({tag, " word count"}, 32'(ncap - b_cap), 32'd16);
    check_words(tag, b_cap, 16, base);
    check({tag, " contiguous"}, 32'(capc[b_cap + 15] - capc[b_cap]), 32'd15);
    check({tag, " done count"}, 32'(ndone - b_done), 32'd1);
    check({tag, " done on word16"}, 32'(done_pos - b_cap), 32'd16);
    check({tag, " pops"}, 32'(npops - b_pops), 32'd8);
    check({tag, " protocol"}, 32'(nbad - b_bad), 32'd0);
    check({tag, " busy idle"}, 32'(bus.busy), 32'd0);
  endtask

  typedef struct {
    logic [29:0] addr;
    logic [15:0] base;
    logic [29:0] exp_addr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int b_cap, b_cmd, b_done, b_pops, c_drop;

    vecs[0] = '{addr: 30'h0000_0100, base: 16'h0001, exp_addr: 30'h0000_0100};
    vecs[1] = '{addr: 30'h0000_0103, base: 16'h1000, exp_addr: 30'h0000_0100};
    vecs[2] = '{addr: 30'h3FFF_FFFF, base: 16'hFFF0, exp_addr: 30'h3FFF_FFFC};
    vecs[3] = '{addr: 30'h0000_0202, base: 16'h8000, exp_addr: 30'h0000_0200};

    bus.reads_en = 1'b0;
    bus.addr     = '0;
    bus.cmd_full = 1'b0;
    step(3);
    check("reset ob_we", 32'(bus.ob_we), 32'd0);
    check("reset ob_data", 32'(bus.ob_data), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset cmd_en", 32'(bus.cmd_en), 32'd0);
    check("reset cmd_instr", 32'(bus.cmd_instr), 32'd0);
    check("reset cmd_bl", 32'(bus.cmd_bl), 32'd0);
    check("reset cmd_byte_addr", 32'(bus.cmd_byte_addr), 32'd0);
    check("reset rd_en", 32'(bus.rd_en), 32'd0);
    rst_n = 1'b1;
    step(2);

    for (int v = 0; v < 4; v++) begin
      run_burst($sformatf("vec%0d", v), vecs[v].addr, vecs[v].base, vecs[v].exp_addr);
    end

    // command FIFO full for the first cycles of CMD
    fill(16'h0100);
    b_cap = ncap; b_cmd = ncmd;
    bus.cmd_full = 1'b1;
    bus.addr     = 30'h0000_0300;
    bus.reads_en = 1'b1;
    step(5);
    check("cmd_full no cmd", 32'(ncmd - b_cmd), 32'd0);
    check("cmd_full busy", 32'(bus.busy), 32'd1);
    c_drop = cyc;
    bus.cmd_full = 1'b0;
    step(25);
    bus.reads_en = 1'b0;
    step(2);
    check("cmd_full cmd once", 32'(ncmd - b_cmd), 32'd1);
    check("cmd_full cmd cycle", 32'(cmd_cyc), 32'(c_drop));
    check("cmd_full words", 32'(ncap - b_cap), 32'd16);
    check_words("cmd_full", b_cap, 16, 16'h0100);

    // read FIFO empty for 3 cycles at the third pop opportunity
    fill(16'h2000);
    b_cap = ncap; b_done = ndone; b_pops = npops;
    bus.addr     = 30'h0000_0400;
    bus.reads_en = 1'b1;
    wait_count("gap wait pop2", 0, b_pops, 2);
    step(1);
    stall = 1'b1;
    step(3);
    stall = 1'b0;
    step(30);
    bus.reads_en = 1'b0;
    step(2);
    check("gap words", 32'(ncap - b_cap), 32'd16);
    check_words("gap", b_cap, 16, 16'h2000);
    check("gap length", 32'(capc[b_cap + 4] - capc[b_cap + 3]), 32'd4);
    check("gap before", 32'(capc[b_cap + 3] - capc[b_cap]), 32'd3);
    check("gap after", 32'(capc[b_cap + 15] - capc[b_cap + 4]), 32'd11);
    check("gap done", 32'(ndone - b_done), 32'd1);

    // abort after five words, three pops
    fill(16'h3000);
    b_cap = ncap; b_cmd = ncmd; b_done = ndone; b_pops = npops;
    bus.addr     = 30'h0000_0500;
    bus.reads_en = 1'b1;
    wait_count("abort wait", 1, b_cap, 4);
    bus.reads_en = 1'b0;
    step(1);
    check("abort ob_we low", 32'(bus.ob_we), 32'd0);
    check("abort pops at drop", 32'(npops - b_pops), 32'd3);
    step(15);
    check("abort words", 32'(ncap - b_cap), 32'd5);
    check_words("abort", b_cap, 5, 16'h3000);
    check("abort total pops", 32'(npops - b_pops), 32'd8);
    check("abort fifo empty", 32'(wr_ptr == rd_ptr), 32'd1);
    check("abort no done", 32'(ndone - b_done), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort rd_en", 32'(bus.rd_en), 32'd0);
    check("abort cmds", 32'(ncmd - b_cmd), 32'd1);

    // reads_en held across completion must not retrigger
    fill(16'h4000);
    b_cap = ncap; b_cmd = ncmd; b_done = ndone;
    bus.addr     = 30'h0000_0100;
    bus.reads_en = 1'b1;
    step(40);
    check("hold cmds", 32'(ncmd - b_cmd), 32'd1);
    check("hold words", 32'(ncap - b_cap), 32'd16);
    check("hold busy", 32'(bus.busy), 32'd0);
    bus.reads_en = 1'b0;
    step(1);
    fill(16'h5000);
    bus.addr     = 30'h0000_0200;
    bus.reads_en = 1'b1;
    step(25);
    bus.reads_en = 1'b0;
    step(2);
    check("rearm cmds", 32'(ncmd - b_cmd), 32'd2);
    check("rearm addr", 32'(cmd_addr_s), 32'h0000_0200);
    check("rearm words", 32'(ncap - b_cap), 32'd32);
    check_words("rearm", b_cap + 16, 16, 16'h5000);
    check("rearm done", 32'(ndone - b_done), 32'd2);

    // asynchronous reset in the middle of READ
    fill(16'h6000);
    b_cap = ncap; b_cmd = ncmd;
    bus.addr     = 30'h0000_0600;
    bus.reads_en = 1'b1;
    wait_count("rst wait", 1, b_cap, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst ob_we", 32'(bus.ob_we), 32'd0);
    check("rst ob_data", 32'(bus.ob_data), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst rd_en", 32'(bus.rd_en), 32'd0);
    check("rst cmd_byte_addr", 32'(bus.cmd_byte_addr), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    bus.reads_en = 1'b0;
    step(2);
    wr_ptr = rd_ptr;
    rst_n  = 1'b1;
    step(2);
    check("post rst idle", 32'(bus.busy), 32'd0);
    check("post rst no cmd", 32'(ncmd - b_cmd), 32'd1);
    run_burst("post_rst", 30'h0000_0701, 16'h7000, 30'h0000_0700);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_rd_channel.md
Name: dma_rd_channel

Overview:
- Read-side DMA channel placed between one MIG-style user read port and one engine read port (p2/p3/p4/p5 data or weight stream).
- On a read request it issues one burst read command and pops 32-bit words from the MIG read FIFO.
- It splits each word into 16-bit halves and streams them to the engine one per cycle on ob_data/ob_we.
- One instance is used per engine read port.

Parameters:
- BURST_LEN, 16: 16-bit words per request. Must be even, range 2..128.
- ADDR_W, 30: width of the engine address and the MIG byte address.
- DQ_W, 32: MIG read data width. Fixed at 2x16; other values are unsupported.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- reads_en  in  1  engine read request, level; rising edge starts a burst, low aborts
- addr  in  ADDR_W  burst start byte address, sampled at start
- ob_data  out  16  stream word to engine
- ob_we  out  1  ob_data valid, one word per asserted cycle
- busy  out  1  high from start until return to IDLE
- done  out  1  one-cycle pulse when a complete burst has been streamed
- cmd_en  out  1  MIG command strobe
- cmd_instr  out  3  MIG command; 3'b001 (read) whenever cmd_en=1
- cmd_bl  out  6  burst length minus 1 = BURST_LEN/2-1
- cmd_byte_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
- cmd_full  in  1  MIG command FIFO full
- rd_en  out  1  pop MIG read FIFO
- rd_data  in  DQ_W  MIG read data, first-word-fall-through
- rd_empty  in  1  MIG read FIFO empty

Behaviour:
- Reset (rst_n=0): state=IDLE.
  - All outputs 0: ob_data=0, ob_we=0, busy=0, done=0, cmd_en=0, cmd_instr=0, cmd_bl=0, cmd_byte_addr=0, rd_en=0.
  - armed=1; word and pop counters=0.
  - Reset mid-burst abandons the burst immediately. No drain is performed; recovering the MIG FIFO is the system's responsibility.
- Arming: `armed` clears on start and sets on any cycle with reads_en=0. A start requires reads_en=1 and armed=1, so holding reads_en high never retriggers.
- IDLE: on start, latch cmd_byte_addr, set busy=1, go to CMD.
- CMD:
  - With cmd_full=0: drive cmd_en=1 for exactly one cycle, with cmd_instr=3'b001 and cmd_bl=BURST_LEN/2-1, then go to READ.
  - With cmd_full=1: hold in CMD, cmd_en=0.
- READ, pop rule: rd_en=1 combinationally when rd_empty=0 and no upper half is pending. rd_data is valid in the same cycle.
- READ, pop cycle: register ob_data=rd_data[15:0] with ob_we=1 on the next edge, store rd_data[31:16] as pending.
- READ, following cycle: output the pending half with ob_we=1 and clear pending.
- Throughput: one 16-bit word per cycle when the FIFO is non-empty; lower half first.
- Latency: from rd_en&!rd_empty to the first ob_we is 1 cycle.
- Completion: when the BURST_LEN-th word is emitted, pulse done=1 in that same cycle as the final ob_we, drop busy, and go to IDLE on the next edge.
- Abort: reads_en=0 while in CMD or READ.
  - ob_we is forced to 0 from the next cycle; a pending half is discarded.
  - From CMD with the command not yet issued: go to IDLE with no command.
  - Otherwise go to DRAIN.
- DRAIN: pop the remaining BURST_LEN/2 - pops words (rd_en when !rd_empty), with no output. Then go to IDLE with busy=0. done is never pulsed for an aborted burst.
- Boundaries:
  - A start request during busy is ignored.
  - The pop counter is 8-bit and the word counter is 8-bit; they never wrap for legal BURST_LEN.
  - addr[1:0]≠0: the low address bits are silently cleared.
  - rd_empty toggling mid-burst stalls the stream; gaps in ob_we are legal.

Decomposition:
- Shared package defines:
  - MIG instruction constants: MIG_WR=3'b000, MIG_RD=3'b001.
  - Channel state encoding: IDLE, CMD, READ, DRAIN.
  - Default BURST_LEN.
- No sub-module is needed beyond an optional word_splitter (32→16 halving register with pending flag).

Test Plan:
- Basic burst: BURST_LEN=16, addr=0x100, FIFO pre-filled with 8 words 0x0002_0001..0x0010_000F.
  - One cmd_en with bl=7 and byte_addr=0x100.
  - ob_we for 16 consecutive cycles with ob_data 0x0001,0x0002,…,0x0010.
  - done coincides with word 16; busy falls.
- cmd_full held 5 cycles after start: cmd_en is asserted only on the first cycle with cmd_full=0, exactly once.
- rd_empty pulsed high for 3 cycles after the 2nd pop: ob_we gap of 3 cycles, 16 words total, order preserved.
- Abort: reads_en dropped after 5 words emitted (3 pops).
  - ob_we is 0 from the next cycle.
  - Exactly 5 further rd_en pops occur, then IDLE.
  - done is never asserted.
- reads_en held high across burst completion: no second cmd_en. After reads_en is low 1 cycle and high again with addr=0x200, a new cmd_en with byte_addr=0x200 is issued.
- rst_n asserted mid-READ: all outputs are 0 asynchronously. After release, the first reads_en rising edge starts a clean burst.
